// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the 2-way cache.
package cache_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int OFFSET_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    REQ,
    FILL,
    DONE
  } state_e;

  // Byte offset inside a block.
  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Set index, right-aligned; the caller truncates to its index width.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int index_w);
    return (addr >> OFFSET_W) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
  endfunction

  // Tag, right-aligned; the caller truncates to its tag width.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int index_w);
    return addr >> (OFFSET_W + index_w);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set tag, valid, dirty and 4-byte data line.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int SETS    = 32,
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INDEX_W-1:0]            index,
  output logic [TAG_W-1:0]              tag,
  output logic                          valid,
  output logic                          dirty,
  output logic [DATA_W*BLOCK_BYTES-1:0] line,
  input  logic                          byte_we,
  input  logic [OFFSET_W-1:0]           byte_offset,
  input  logic [DATA_W-1:0]             byte_data,
  input  logic                          set_dirty,
  input  logic                          install,
  input  logic [TAG_W-1:0]              install_tag
);

  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][BLOCK_BYTES];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  assign tag   = tag_q[index];
  assign valid = valid_q[index];
  assign dirty = dirty_q[index];

  // Present the whole indexed line, byte 0 in the low bits.
  always_comb begin
    line = '0;
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      line[b*DATA_W +: DATA_W] = data_q[index][b];
    end
  end

  // Status bits: cleared by reset, set on install, dirtied by CPU writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (install) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (byte_we && set_dirty) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage.
  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (byte_we) data_q[index][byte_offset] <= byte_data;
    if (install) tag_q[index] <= install_tag;
  end

endmodule

// File: rtl/cache_2way_set_assoc.sv
// Blocking 2-way set-associative write-back/write-allocate cache with 1-bit LRU per set.
module cache_2way_set_assoc
  import cache_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int RD_LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  inout  wire  [DATA_W-1:0] data_cpu,
  inout  wire  [DATA_W-1:0] data_mem,
  input  logic [ADDR_W-1:0] addr_cpu,
  output logic [ADDR_W-1:0] addr_mem,
  input  logic              rd_cpu,
  input  logic              wr_cpu,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic              stall_cpu,
  input  logic              ready_mem
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LAT_W   = $clog2(RD_LATENCY) + 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   miss_addr;
  logic                victim_q;
  logic                wb_go;
  logic [OFFSET_W-1:0] wb_cnt;
  logic [OFFSET_W-1:0] fill_k;
  logic [LAT_W-1:0]    lat_cnt;
  logic [SETS-1:0]     lru_q;    // per set: the way to evict next

  logic [INDEX_W-1:0]  cpu_index, miss_index, way_index;
  logic [TAG_W-1:0]    cpu_tag, miss_tag;
  logic [OFFSET_W-1:0] cpu_offset, byte_offset;
  logic [DATA_W-1:0]   byte_data, rd_byte, wb_byte;

  logic [TAG_W-1:0]              way_tag  [2];
  logic [DATA_W*BLOCK_BYTES-1:0] way_line [2];
  logic [1:0] way_valid, way_dirty, hit_vec, byte_we, install_we;
  logic lookup, access, hit, hit_way, serve, miss, cpu_write;
  logic fill_sample, fill_last, victim_nxt;

  assign cpu_index  = INDEX_W'(addr_index(addr_cpu, INDEX_W));
  assign cpu_tag    = TAG_W'(addr_tag(addr_cpu, INDEX_W));
  assign cpu_offset = addr_offset(addr_cpu);
  assign miss_index = INDEX_W'(addr_index(miss_addr, INDEX_W));
  assign miss_tag   = TAG_W'(addr_tag(miss_addr, INDEX_W));

  // The CPU address owns the arrays only when a lookup can complete; otherwise the latched miss does.
  assign lookup    = (state == IDLE) || (state == DONE);
  assign way_index = lookup ? cpu_index : miss_index;

  assign hit       = |hit_vec;
  assign hit_way   = hit_vec[1];
  assign access    = rd_cpu | wr_cpu;
  assign serve     = lookup & access & hit;
  assign miss      = (state == IDLE) & access & ~hit;
  assign cpu_write = serve & wr_cpu;
  assign stall_cpu = reset_n & access & ~serve;

  assign rd_byte  = way_line[hit_way][cpu_offset*DATA_W +: DATA_W];
  assign data_cpu = (reset_n && serve && rd_cpu && !wr_cpu) ? rd_byte : 'z;
  assign data_mem = wr_mem ? wb_byte : 'z;

  // First invalid way wins; with both valid the LRU way is evicted.
  assign victim_nxt = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[cpu_index]);

  assign fill_sample = (state == FILL) && (lat_cnt == LAT_LAST);
  assign fill_last   = fill_sample && (fill_k == '1);
  assign byte_offset = (state == FILL) ? fill_k : cpu_offset;
  assign byte_data   = (state == FILL) ? data_mem : data_cpu;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit_vec[w]    = way_valid[w] && (way_tag[w] == cpu_tag);
    assign byte_we[w]    = (cpu_write & hit_vec[w]) | (fill_sample & (victim_q == 1'(w)));
    assign install_we[w] = fill_last & (victim_q == 1'(w));

    cache_way_array #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk         (clock),
      .rst_n       (reset_n),
      .index       (way_index),
      .tag         (way_tag[w]),
      .valid       (way_valid[w]),
      .dirty       (way_dirty[w]),
      .line        (way_line[w]),
      .byte_we     (byte_we[w]),
      .byte_offset (byte_offset),
      .byte_data   (byte_data),
      .set_dirty   (cpu_write),
      .install     (install_we[w]),
      .install_tag (miss_tag)
    );
  end

  // Next state and memory-port outputs.
  always_comb begin
    // NOTE: every output is defaulted before the case so no path can leave one unassigned and infer a latch.
    state_nxt = state;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    addr_mem  = '0;
    wb_byte   = '0;
    unique case (state)
      IDLE: if (miss) state_nxt = (way_valid[victim_nxt] && way_dirty[victim_nxt]) ? WB : REQ;
      WB: begin
        if (wb_go) begin
          wr_mem   = 1'b1;
          addr_mem = {way_tag[victim_q], miss_index, wb_cnt};
          wb_byte  = way_line[victim_q][wb_cnt*DATA_W +: DATA_W];
          if (wb_cnt == '1) state_nxt = REQ;
        end
      end
      REQ: if (ready_mem) state_nxt = FILL;
      FILL: begin
        rd_mem   = 1'b1;
        addr_mem = {miss_addr[ADDR_W-1:OFFSET_W], fill_k};
        if (fill_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus miss bookkeeping: write-back beat count and fill latency/byte counters.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    if (!reset_n) begin
      state     <= IDLE;
      miss_addr <= '0;
      victim_q  <= 1'b0;
      wb_go     <= 1'b0;
      wb_cnt    <= '0;
      lat_cnt   <= '0;
      fill_k    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (miss) begin
            miss_addr <= addr_cpu;
            victim_q  <= victim_nxt;
            wb_go     <= 1'b0;
            wb_cnt    <= '0;
            lat_cnt   <= '0;
            fill_k    <= '0;
          end
        end
        WB: begin
          if (wb_go) wb_cnt <= wb_cnt + 1'b1;
          else if (ready_mem) wb_go <= 1'b1;
        end
        FILL: begin
          if (lat_cnt != LAT_LAST) lat_cnt <= lat_cnt + 1'b1;
          if (fill_sample) fill_k <= fill_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // LRU: an accessed or freshly installed way becomes MRU.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lru_q <= '0;
    end else if (serve) begin
      lru_q[cpu_index] <= ~hit_way;
    end else if (fill_last) begin
      lru_q[miss_index] <= ~victim_q;
    end
  end

endmodule

// File: tb/tb_cache_2way_set_assoc.sv
// Directed bench for the 2-way cache: CPU steps in one initial block, a small memory responder alongside.
module tb_cache_2way_set_assoc;

  localparam int LAT = 5;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic [15:0] addr_cpu  = '0;
  logic        rd_cpu    = 1'b0;
  logic        wr_cpu    = 1'b0;
  logic        ready_mem = 1'b1;
  logic        cpu_oe    = 1'b0;
  logic        mem_oe    = 1'b0;
  logic [7:0]  cpu_drv   = '0;
  logic [7:0]  mem_drv   = '0;
  wire  [7:0]  data_cpu;
  wire  [7:0]  data_mem;
  logic [15:0] addr_mem;
  logic        rd_mem, wr_mem, stall_cpu;

  assign data_cpu = cpu_oe ? cpu_drv : 'z;
  assign data_mem = mem_oe ? mem_drv : 'z;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fill_bytes [4];
  logic [15:0] rd_addr_q   [$];
  logic [15:0] samp_addr_q [$];
  logic [15:0] wb_addr_q   [$];
  logic [7:0]  wb_data_q   [$];
  int rd_cyc   = 0;
  int rd_total = 0;
  int overlap  = 0;

  cache_2way_set_assoc #(.SETS(32), .RD_LATENCY(LAT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .data_cpu  (data_cpu),
    .data_mem  (data_mem),
    .addr_cpu  (addr_cpu),
    .addr_mem  (addr_mem),
    .rd_cpu    (rd_cpu),
    .wr_cpu    (wr_cpu),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .stall_cpu (stall_cpu),
    .ready_mem (ready_mem)
  );

  always #5 clock = ~clock;

  // Memory: logs write beats and the first read address, returns byte k in read cycle LAT+k (1-based).
  always @(negedge clock) begin
    if (rd_mem && wr_mem) overlap++;
    if (wr_mem) begin
      wb_addr_q.push_back(addr_mem);
      wb_data_q.push_back(data_mem);
    end
    if (rd_mem) begin
      rd_cyc++;
      rd_total++;
      if (rd_cyc == 1) rd_addr_q.push_back(addr_mem);
      if (rd_cyc >= LAT && rd_cyc < LAT + 4) begin
        mem_oe  = 1'b1;
        mem_drv = fill_bytes[rd_cyc-LAT];
        samp_addr_q.push_back(addr_mem);
      end else begin
        mem_oe = 1'b0;
      end
    end else begin
      rd_cyc = 0;
      mem_oe = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    samp_addr_q.delete();
    wb_addr_q.delete();
    wb_data_q.delete();
  endtask

  task automatic wait_unstall(input string tag);
    int n = 0;
    while (stall_cpu === 1'b1 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(tag, 16'(stall_cpu), 16'd0);
  endtask

  task automatic check_rd_addr(input string tag, input logic [15:0] exp);
    check(tag, (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hFFFF, exp);
  endtask

  initial begin
    logic [7:0] exp_wb [4];
    int n;
    int base_rd;
    int base_wb;

    // Reset state
    #2;
    check("reset stall_cpu", 16'(stall_cpu), 16'd0);
    check("reset rd_mem", 16'(rd_mem), 16'd0);
    check("reset wr_mem", 16'(wr_mem), 16'd0);
    check("reset addr_mem", addr_mem, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;

    // Cold read miss, set 2 way 0
    @(negedge clock);
    clear_logs();
    fill_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    addr_cpu = 16'hC08B;
    rd_cpu   = 1'b1;
    #1 check("cold miss stall", 16'(stall_cpu), 16'd1);
    wait_unstall("cold miss unstall");
    check("cold miss data", 16'(data_cpu), 16'h0044);
    check_rd_addr("cold rd_mem addr", 16'hC088);
    for (int k = 0; k < 4; k++)
      check($sformatf("cold fill addr%0d", k),
            (samp_addr_q.size() > k) ? samp_addr_q[k] : 16'hFFFF, 16'hC088 + 16'(k));
    check("cold no write-back", 16'(wb_addr_q.size()), 16'd0);
    @(negedge clock);
    rd_cpu = 1'b0;

    // Read hit, same cycle
    @(negedge clock);
    base_rd  = rd_total;
    addr_cpu = 16'hC088;
    rd_cpu   = 1'b1;
    #1 check("read hit stall", 16'(stall_cpu), 16'd0);
    check("read hit data", 16'(data_cpu), 16'h0011);
    check("read hit rd_mem", 16'(rd_mem), 16'd0);
    @(negedge clock);
    #1 check("read hit no memory read", 16'(rd_total - base_rd), 16'd0);

    // Write hit then read back
    @(negedge clock);
    base_wb  = wb_addr_q.size();
    rd_cpu   = 1'b0;
    addr_cpu = 16'hC089;
    cpu_drv  = 8'hAA;
    cpu_oe   = 1'b1;
    wr_cpu   = 1'b1;
    #1 check("write hit stall", 16'(stall_cpu), 16'd0);
    @(negedge clock);
    wr_cpu = 1'b0;
    cpu_oe = 1'b0;
    rd_cpu = 1'b1;
    #1 check("write hit readback", 16'(data_cpu), 16'h00AA);
    check("write hit no wr_mem", 16'(wb_addr_q.size() - base_wb), 16'd0);
    @(negedge clock);
    rd_cpu = 1'b0;

    // Second way of set 2, clean victim (invalid way 1)
    @(negedge clock);
    clear_logs();
    fill_bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
    addr_cpu = 16'h408B;
    rd_cpu   = 1'b1;
    #1 check("way1 miss stall", 16'(stall_cpu), 16'd1);
    wait_unstall("way1 miss unstall");
    check("way1 miss data", 16'(data_cpu), 16'h0088);
    check("way1 no write-back", 16'(wb_addr_q.size()), 16'd0);
    check_rd_addr("way1 rd_mem addr", 16'h4088);
    @(negedge clock);
    addr_cpu = 16'hC08A;
    #1 check("way0 still resident", 16'(data_cpu), 16'h0033);
    @(negedge clock);
    addr_cpu = 16'h4088;
    #1 check("way1 byte0", 16'(data_cpu), 16'h0055);
    @(negedge clock);
    rd_cpu = 1'b0;

    // Dirty eviction of way 0 (tag 0x181)
    @(negedge clock);
    clear_logs();
    fill_bytes = '{8'h99, 8'hA1, 8'hB2, 8'hC3};
    exp_wb     = '{8'h11, 8'hAA, 8'h33, 8'h44};
    addr_cpu = 16'h808B;
    rd_cpu   = 1'b1;
    #1 check("evict miss stall", 16'(stall_cpu), 16'd1);
    wait_unstall("evict unstall");
    check("evict data", 16'(data_cpu), 16'h00C3);
    check("evict wb beats", 16'(wb_addr_q.size()), 16'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("evict wb addr%0d", k),
            (wb_addr_q.size() > k) ? wb_addr_q[k] : 16'hFFFF, 16'hC088 + 16'(k));
      check($sformatf("evict wb data%0d", k),
            (wb_data_q.size() > k) ? 16'(wb_data_q[k]) : 16'hFFFF, 16'(exp_wb[k]));
    end
    check_rd_addr("evict rd_mem addr", 16'h8088);
    @(negedge clock);
    rd_cpu = 1'b0;

    // Reset in the middle of a fill
    @(negedge clock);
    clear_logs();
    fill_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    addr_cpu = 16'hC08B;
    rd_cpu   = 1'b1;
    #1 check("abort miss stall", 16'(stall_cpu), 16'd1);
    n = 0;
    while (samp_addr_q.size() < 2 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("abort reached byte1", 16'(samp_addr_q.size() >= 2), 16'd1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("abort rd_mem", 16'(rd_mem), 16'd0);
    check("abort stall", 16'(stall_cpu), 16'd0);
    check("abort wr_mem", 16'(wr_mem), 16'd0);
    check("abort addr_mem", addr_mem, 16'h0000);
    @(negedge clock);
    #1;
    clear_logs();
    reset_n = 1'b1;
    #1 check("post-reset misses again", 16'(stall_cpu), 16'd1);
    wait_unstall("post-reset unstall");
    check("post-reset data", 16'(data_cpu), 16'h00EF);
    check("post-reset no write-back", 16'(wb_addr_q.size()), 16'd0);
    check_rd_addr("post-reset rd_mem addr", 16'hC088);
    @(negedge clock);
    rd_cpu = 1'b0;

    @(negedge clock);
    check("rd_mem/wr_mem overlap", 16'(overlap), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
